dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences the single data-memory port and shares it between the pipeline memory stage (LSU,
//  port 0) and the program/data loader (LDR, port 1). Converts level requests into one-shot
//  memory transactions and waits for the variable-latency mem_valid response. Produces the LSU
//  pipeline stall. Returns read data or a timeout error to the owning requester.
// PARAMETERS
//  ADDR_W          32   address width, both ports and memory side
//  DATA_W          32   data width; mask width is DATA_W/8
//  TIMEOUT_CYCLES  255  WAIT cycles without mem_valid before error completion; 0 = never; max 255
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       reset, asynchronous, active-low
//  lsu_request   in   1       LSU access request; held stable until lsu_valid
//  lsu_we_re     in   1       1 = store, 0 = load
//  lsu_addr      in   ADDR_W  byte address
//  lsu_wdata     in   DATA_W  store data, already lane-aligned
//  lsu_mask      in   DW/8    byte-lane enables
//  lsu_stall     out  1       hold the pipeline
//  lsu_valid     out  1       1-cycle completion pulse
//  lsu_rdata     out  DATA_W  load data; valid with lsu_valid
//  lsu_err       out  1       timeout flag; valid with lsu_valid
//  ldr_request, ldr_we_re, ldr_addr, ldr_wdata, ldr_mask   in    same meanings, loader port
//  ldr_valid, ldr_rdata, ldr_err                            out   same meanings, loader port
//  mem_request   out  1       1-cycle transaction strobe
//  mem_we_re     out  1       write enable
//  mem_addr      out  ADDR_W  registered address
//  mem_wdata     out  DATA_W  registered write data
//  mem_mask      out  DW/8    registered byte mask
//  mem_valid     in   1       completion from memory; latency >= 1 cycle after mem_request
//  mem_rdata     in   DATA_W  read data; valid with mem_valid
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; owner=LSU; last_grant=LDR, so LSU wins first contention.
//    Counter=0. Every output 0. A memory response pending at reset is dropped.
//  - States IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE, entry: taken when any request is high. Grant rules:
//      only one requester high -> that one;
//      both high -> the one not equal to last_grant.
//    Register owner, we/addr/wdata/mask; update last_grant.
//  - ISSUE: mem_request=1 for exactly this cycle; mem_* fields come from registers.
//  - WAIT: mem_request=0; mem_* fields held.
//      mem_valid=1 -> capture mem_rdata, err=0, go RESP.
//      Otherwise counter++; counter==TIMEOUT_CYCLES (when !=0) -> rdata=0, err=1, go RESP.
//  - RESP: owner's valid=1 for one cycle with captured rdata/err. The other port's valid=0. Go IDLE.
//    Counter clears.
//  - Store completions also pulse valid, with rdata=0.
//  - mem_valid outside WAIT is ignored.
//  - Minimum latency, request to valid: 3 cycles (accept, ISSUE, WAIT with mem_valid, then RESP).
//    Back-to-back: next grant is evaluated in the IDLE cycle after RESP.
//  - lsu_stall = lsu_request & ~(state==RESP & owner==LSU), combinational. It is high while the
//    LDR owns the port.
//  - A requester that drops its request mid-transaction does not cancel it. The transaction
//    completes and the valid pulse is still issued.
//  - Request fields are sampled only in IDLE; changes during ISSUE/WAIT/RESP have no effect.
// STRUCTURE
//  - dmem_defs.vh: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3) and owner IDs
//    (OWN_LSU=1'b0, OWN_LDR=1'b1).
//  - Sub-module rr_arb2: 2-way round-robin pick (req0, req1, last -> gnt, id). Combinational.
//    Last-grant state stays in the parent.
// TESTING
//  1. Reset mid-WAIT: assert rst=0 during WAIT -> all outputs 0 immediately.
//     Then release and drive mem_valid=1 -> no valid pulse; next LSU request wins.
//  2. LSU load, addr=0x100, memory latency 1 -> mem_request one pulse on cycle 1 with addr 0x100.
//     lsu_valid on cycle 3 with rdata=0xDEADBEEF. lsu_stall high on cycles 0-2, low on cycle 3.
//  3. LSU store, mask=4'b0011, wdata=0x0000ABCD -> mem_we_re=1 and mem_mask=0011 during ISSUE.
//     lsu_valid=1 with rdata=0.
//  4. Both request continuously -> grants alternate LSU, LDR, LSU, LDR. lsu_stall is high during
//     LDR ownership.
//  5. TIMEOUT_CYCLES=4, memory never responds -> RESP after 4 WAIT cycles.
//     lsu_valid=1, lsu_err=1, lsu_rdata=0; the following access completes normally.
//  6. LDR drops ldr_request after ISSUE -> ldr_valid still pulses once. No second mem_request.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller.
//   state_e : sequencer states (IDLE -> ISSUE -> WAIT -> RESP)
//   owner_e : requester identity (LSU = port 0, LDR = port 1)
//   TMO_W   : width of the response timeout timer (timeout is capped at 255)
package dmem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_LSU = 1'b0,
      OWN_LDR = 1'b1
   } owner_e;

   localparam int TMO_W = 8;

   // Round-robin choice when both ports request: whoever was not granted last.
   function automatic owner_e rr_pick(input logic req0, input logic req1, input owner_e last);
      if (req0 && req1) return (last == OWN_LSU) ? OWN_LDR : OWN_LSU;
      if (req1)         return OWN_LDR;
      return OWN_LSU;
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_rr_arb2.sv
// 2-way round-robin pick (rr_arb2), purely combinational.
// Ports:
//   req0 / req1 : LSU / LDR request levels
//   last        : port granted most recently (state kept by the parent)
//   gnt         : some port is requesting
//   id          : port to serve
module dmem_access_ctrl_rr_arb2
   import dmem_access_ctrl_pkg::*;
(
   input  logic   req0,
   input  logic   req1,
   input  owner_e last,
   output logic   gnt,
   output owner_e id
);

   always_comb begin
      gnt = req0 | req1;
      id  = rr_pick(req0, req1, last);
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: shares one memory port between the LSU
// (port 0) and the loader (port 1), turns level requests into single-cycle
// memory strobes, waits for mem_valid (or times out) and returns a one-cycle
// completion pulse with data/error to the owning port.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   lsu_* / ldr_* inputs     request, we_re, addr, wdata, mask per port
//   lsu_stall                hold the pipeline while an LSU access is pending
//   lsu_* / ldr_* outputs    valid pulse, rdata, err per port
//   mem_* outputs            registered transaction fields, 1-cycle mem_request
//   mem_valid, mem_rdata     memory response
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | port free; arbitrate and latch the winner's request fields
// ST_ISSUE | mem_request high for this single cycle
// ST_WAIT  | wait for mem_valid; timeout timer counts down
// ST_RESP  | owner's valid pulse with captured rdata/err
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                lsu_request,
   input  logic                lsu_we_re,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_mask,
   output logic                lsu_stall,
   output logic                lsu_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_err,

   input  logic                ldr_request,
   input  logic                ldr_we_re,
   input  logic [ADDR_W-1:0]   ldr_addr,
   input  logic [DATA_W-1:0]   ldr_wdata,
   input  logic [DATA_W/8-1:0] ldr_mask,
   output logic                ldr_valid,
   output logic [DATA_W-1:0]   ldr_rdata,
   output logic                ldr_err,

   output logic                mem_request,
   output logic                mem_we_re,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_mask,
   input  logic                mem_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int MASK_W = DATA_W / 8;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);
   localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   owner_e              last_q, last_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   mask_q, mask_d;
   logic                mem_request_q, mem_request_d;
   logic                lsu_valid_q, lsu_valid_d;
   logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
   logic                lsu_err_q, lsu_err_d;
   logic                ldr_valid_q, ldr_valid_d;
   logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
   logic                ldr_err_q, ldr_err_d;

   logic                arb_gnt;
   owner_e              arb_id;
   logic                rsp_fire;
   logic [DATA_W-1:0]   rsp_data;
   logic                rsp_err;

   dmem_access_ctrl_rr_arb2 u_arb (
      .req0 (lsu_request),
      .req1 (ldr_request),
      .last (last_q),
      .gnt  (arb_gnt),
      .id   (arb_id)
   );

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      tmo_d         = tmo_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      mask_d        = mask_q;
      mem_request_d = 1'b0;
      rsp_fire      = 1'b0;
      rsp_data      = '0;
      rsp_err       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_gnt) begin
               state_d       = ST_ISSUE;
               owner_d       = arb_id;
               last_d        = arb_id;
               mem_request_d = 1'b1;
               if (arb_id == OWN_LDR) begin
                  we_d    = ldr_we_re;
                  addr_d  = ldr_addr;
                  wdata_d = ldr_wdata;
                  mask_d  = ldr_mask;
               end else begin
                  we_d    = lsu_we_re;
                  addr_d  = lsu_addr;
                  wdata_d = lsu_wdata;
                  mask_d  = lsu_mask;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            tmo_d   = TMO_LOAD;
         end
         ST_WAIT: begin
            if (mem_valid) begin
               state_d  = ST_RESP;
               rsp_fire = 1'b1;
               // Stores report zero data regardless of what the memory drives.
               rsp_data = we_q ? '0 : mem_rdata;
            end else if (TMO_EN && tmo_q == TMO_W'(1)) begin
               state_d  = ST_RESP;
               rsp_fire = 1'b1;
               rsp_err  = 1'b1;
               tmo_d    = '0;
            end else if (TMO_EN) begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            tmo_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase

      lsu_valid_d = rsp_fire && (owner_q == OWN_LSU);
      lsu_rdata_d = (rsp_fire && owner_q == OWN_LSU) ? rsp_data : '0;
      lsu_err_d   = rsp_fire && (owner_q == OWN_LSU) && rsp_err;
      ldr_valid_d = rsp_fire && (owner_q == OWN_LDR);
      ldr_rdata_d = (rsp_fire && owner_q == OWN_LDR) ? rsp_data : '0;
      ldr_err_d   = rsp_fire && (owner_q == OWN_LDR) && rsp_err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         owner_q       <= OWN_LSU;
         last_q        <= OWN_LDR;   // LSU wins the first contention
         tmo_q         <= '0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         mask_q        <= '0;
         mem_request_q <= 1'b0;
         lsu_valid_q   <= 1'b0;
         lsu_rdata_q   <= '0;
         lsu_err_q     <= 1'b0;
         ldr_valid_q   <= 1'b0;
         ldr_rdata_q   <= '0;
         ldr_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_q        <= last_d;
         tmo_q         <= tmo_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         mask_q        <= mask_d;
         mem_request_q <= mem_request_d;
         lsu_valid_q   <= lsu_valid_d;
         lsu_rdata_q   <= lsu_rdata_d;
         lsu_err_q     <= lsu_err_d;
         ldr_valid_q   <= ldr_valid_d;
         ldr_rdata_q   <= ldr_rdata_d;
         ldr_err_q     <= ldr_err_d;
      end
   end

   // Released only in the RESP cycle of an LSU-owned transaction.
   assign lsu_stall   = lsu_request & ~(state_q == ST_RESP && owner_q == OWN_LSU);

   assign lsu_valid   = lsu_valid_q;
   assign lsu_rdata   = lsu_rdata_q;
   assign lsu_err     = lsu_err_q;
   assign ldr_valid   = ldr_valid_q;
   assign ldr_rdata   = ldr_rdata_q;
   assign ldr_err     = ldr_err_q;
   assign mem_request = mem_request_q;
   assign mem_we_re   = we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_mask    = mask_q;

endmodule
